pwm_pattern_generator: RTL and testbench

//  Transmit-side partner of hysteresis_switch: produces a periodic 1-bit pattern

---
 rtl/pwm_pattern_generator.sv | 129 ++++++++++++
 tb/tb_pwm_pattern_generator.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_pattern_generator.sv
// Periodic PWM pattern source: output high for act_level of every act_period ticks.
// New period/level settings are accepted only in IDLE or on a period wrap, so a
// running pattern never produces a shortened or glitched period.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | output held low, counter parked at 0, config loads immediately
// RUN   | counter advances on ticks, config loads only on the wrap tick
module pwm_pattern_generator #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clk__enable,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             clk_enable,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] level,
    output logic             cfg_ack,
    output logic             output_value,
    output logic             period_start
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] counter_q, counter_d;
    logic [WIDTH-1:0] act_period_q, act_period_d;
    logic [WIDTH-1:0] act_level_q, act_level_d;
    logic             output_value_q, output_value_d;
    logic             period_start_q, period_start_d;
    logic             wrap;
    logic             load;
    logic [WIDTH-1:0] eff_period;
    logic [WIDTH-1:0] level_next;

    // Register all state; everything freezes when the clock gate is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            counter_q      <= ZERO;
            act_period_q   <= ONE;
            act_level_q    <= ZERO;
            output_value_q <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            counter_q      <= counter_d;
            act_period_q   <= act_period_d;
            act_level_q    <= act_level_d;
            output_value_q <= output_value_d;
            period_start_q <= period_start_d;
        end
    end

    // Next state: enable alone moves between IDLE and RUN.
    always_comb begin
        state_d = state_q;
        if (clk__enable) begin
            case (state_q)
                IDLE:    if (enable)  state_d = RUN;
                RUN:     if (!enable) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath and outputs: counter, config load, pattern compare, handshake.
    always_comb begin
        counter_d      = counter_q;
        act_period_d   = act_period_q;
        act_level_d    = act_level_q;
        output_value_d = output_value_q;
        period_start_d = period_start_q;
        load           = 1'b0;
        wrap           = (counter_q == (act_period_q - ONE));
        eff_period     = (period == ZERO) ? ONE : period;
        level_next     = act_level_q;

        if (clk__enable) begin
            case (state_q)
                IDLE: begin
                    load           = cfg_valid;
                    level_next     = load ? level : act_level_q;
                    counter_d      = ZERO;
                    period_start_d = enable;
                    output_value_d = enable && (ZERO < level_next);
                end
                RUN: begin
                    if (!enable) begin
                        counter_d      = ZERO;
                        output_value_d = 1'b0;
                        period_start_d = 1'b0;
                    end else if (clk_enable) begin
                        load           = wrap && cfg_valid;
                        level_next     = load ? level : act_level_q;
                        counter_d      = wrap ? ZERO : (counter_q + ONE);
                        period_start_d = wrap;
                        output_value_d = (counter_d < level_next);
                    end else begin
                        period_start_d = 1'b0;
                    end
                end
                default: begin
                    counter_d      = ZERO;
                    output_value_d = 1'b0;
                    period_start_d = 1'b0;
                end
            endcase
        end

        if (load) begin
            act_period_d = eff_period;
            act_level_d  = level;
        end
    end

    assign cfg_ack      = load;
    assign output_value = output_value_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_pattern_generator.sv
// Directed bench for pwm_pattern_generator: one task per scenario, inline checks.
module tb_pwm_pattern_generator;

    logic        clk = 1'b0;
    logic        clk__enable;
    logic        reset_n;
    logic        enable;
    logic        clk_enable;
    logic        cfg_valid;
    logic [15:0] period;
    logic [15:0] level;
    logic        cfg_ack;
    logic        output_value;
    logic        period_start;

    int vectors    = 0;
    int miscompares = 0;

    pwm_pattern_generator #(.WIDTH(16)) dut (
        .clk          (clk),
        .clk__enable  (clk__enable),
        .reset_n      (reset_n),
        .enable       (enable),
        .clk_enable   (clk_enable),
        .cfg_valid    (cfg_valid),
        .period       (period),
        .level        (level),
        .cfg_ack      (cfg_ack),
        .output_value (output_value),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Return to IDLE, load a config, then enable; leaves the DUT at count 0 of RUN.
    task automatic restart(input logic [15:0] p, input logic [15:0] l);
        enable    = 1'b0;
        cfg_valid = 1'b0;
        step();
        period    = p;
        level     = l;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        enable    = 1'b1;
        step();
    endtask

    task automatic test_reset();
        vectors++;
        if (output_value !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_out got %b exp 0", output_value);
        end
        vectors++;
        if (period_start !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_ps got %b exp 0", period_start);
        end
        vectors++;
        if (cfg_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_ack got %b exp 0", cfg_ack);
        end
        clk__enable = 1'b0;
        period      = 16'd4;
        level       = 16'd1;
        cfg_valid   = 1'b1;
        #1;
        vectors++;
        if (cfg_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_gated_ack got %b exp 0", cfg_ack);
        end
        step();
        clk__enable = 1'b1;
    endtask

    task automatic test_basic();
        #1;
        vectors++;
        if (cfg_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_idle_ack got %b exp 1", cfg_ack);
        end
        step();
        cfg_valid = 1'b0;
        #1;
        vectors++;
        if (cfg_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_ack_drop got %b exp 0", cfg_ack);
        end
        enable = 1'b1;
        step();
        for (int k = 0; k < 12; k++) begin
            vectors++;
            if (output_value !== (k % 4 == 0)) begin
                miscompares++;
                $display("FAIL basic_out k=%0d got %b exp %b", k, output_value, (k % 4 == 0));
            end
            vectors++;
            if (period_start !== (k % 4 == 0)) begin
                miscompares++;
                $display("FAIL basic_ps k=%0d got %b exp %b", k, period_start, (k % 4 == 0));
            end
            step();
        end
    endtask

    task automatic test_cfg_at_wrap();
        restart(16'd10, 16'd3);
        for (int k = 0; k < 10; k++) begin
            vectors++;
            if (output_value !== (k < 3)) begin
                miscompares++;
                $display("FAIL wrap_out k=%0d got %b exp %b", k, output_value, (k < 3));
            end
            vectors++;
            if (period_start !== (k == 0)) begin
                miscompares++;
                $display("FAIL wrap_ps k=%0d got %b exp %b", k, period_start, (k == 0));
            end
            if (k >= 4) begin
                period    = 16'd5;
                level     = 16'd5;
                cfg_valid = 1'b1;
                #1;
                vectors++;
                if (cfg_ack !== (k == 9)) begin
                    miscompares++;
                    $display("FAIL wrap_ack k=%0d got %b exp %b", k, cfg_ack, (k == 9));
                end
            end
            step();
        end
        cfg_valid = 1'b0;
        for (int j = 0; j < 15; j++) begin
            vectors++;
            if (output_value !== 1'b1) begin
                miscompares++;
                $display("FAIL wrap_new_out j=%0d got %b exp 1", j, output_value);
            end
            vectors++;
            if (period_start !== (j % 5 == 0)) begin
                miscompares++;
                $display("FAIL wrap_new_ps j=%0d got %b exp %b", j, period_start, (j % 5 == 0));
            end
            step();
        end
    endtask

    task automatic test_period_zero();
        restart(16'd0, 16'd0);
        for (int k = 0; k < 6; k++) begin
            vectors++;
            if (output_value !== 1'b0) begin
                miscompares++;
                $display("FAIL p0_out k=%0d got %b exp 0", k, output_value);
            end
            vectors++;
            if (period_start !== 1'b1) begin
                miscompares++;
                $display("FAIL p0_ps k=%0d got %b exp 1", k, period_start);
            end
            step();
        end
        period    = 16'd0;
        level     = 16'd7;
        cfg_valid = 1'b1;
        #1;
        vectors++;
        if (cfg_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL p0_ack got %b exp 1", cfg_ack);
        end
        step();
        cfg_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            vectors++;
            if (output_value !== 1'b1) begin
                miscompares++;
                $display("FAIL p0_l7_out k=%0d got %b exp 1", k, output_value);
            end
            vectors++;
            if (period_start !== 1'b1) begin
                miscompares++;
                $display("FAIL p0_l7_ps k=%0d got %b exp 1", k, period_start);
            end
            step();
        end
    endtask

    task automatic test_slow_tick();
        clk_enable = 1'b0;
        restart(16'd4, 16'd2);
        for (int i = 0; i < 24; i++) begin
            vectors++;
            if (output_value !== ((i / 6) % 2 == 0)) begin
                miscompares++;
                $display("FAIL slow_out i=%0d got %b exp %b", i, output_value, ((i / 6) % 2 == 0));
            end
            vectors++;
            if (period_start !== (i % 12 == 0)) begin
                miscompares++;
                $display("FAIL slow_ps i=%0d got %b exp %b", i, period_start, (i % 12 == 0));
            end
            clk_enable = (i % 3 == 2);
            step();
        end
        clk__enable = 1'b0;
        clk_enable  = 1'b1;
        for (int g = 0; g < 5; g++) begin
            vectors++;
            if (output_value !== 1'b1 || period_start !== 1'b1) begin
                miscompares++;
                $display("FAIL gate_hold g=%0d got out=%b ps=%b exp out=1 ps=1", g, output_value, period_start);
            end
            step();
        end
        clk__enable = 1'b1;
        step();
        vectors++;
        if (output_value !== 1'b1 || period_start !== 1'b0) begin
            miscompares++;
            $display("FAIL gate_resume1 got out=%b ps=%b exp out=1 ps=0", output_value, period_start);
        end
        step();
        vectors++;
        if (output_value !== 1'b0 || period_start !== 1'b0) begin
            miscompares++;
            $display("FAIL gate_resume2 got out=%b ps=%b exp out=0 ps=0", output_value, period_start);
        end
    endtask

    task automatic test_disable_mid();
        clk_enable = 1'b1;
        restart(16'd8, 16'd5);
        step();
        step();
        vectors++;
        if (output_value !== 1'b1) begin
            miscompares++;
            $display("FAIL dis_pre_out got %b exp 1", output_value);
        end
        enable    = 1'b0;
        period    = 16'd3;
        level     = 16'd0;
        cfg_valid = 1'b1;
        #1;
        vectors++;
        if (cfg_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL dis_ack got %b exp 0", cfg_ack);
        end
        step();
        cfg_valid = 1'b0;
        vectors++;
        if (output_value !== 1'b0 || period_start !== 1'b0) begin
            miscompares++;
            $display("FAIL dis_idle got out=%b ps=%b exp out=0 ps=0", output_value, period_start);
        end
        step();
        enable = 1'b1;
        step();
        for (int k = 0; k < 10; k++) begin
            vectors++;
            if (output_value !== (k % 8 < 5)) begin
                miscompares++;
                $display("FAIL dis_re_out k=%0d got %b exp %b", k, output_value, (k % 8 < 5));
            end
            vectors++;
            if (period_start !== (k % 8 == 0)) begin
                miscompares++;
                $display("FAIL dis_re_ps k=%0d got %b exp %b", k, period_start, (k % 8 == 0));
            end
            if (k < 9) step();
        end
    endtask

    task automatic test_async_reset();
        #3;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (output_value !== 1'b0 || period_start !== 1'b0) begin
            miscompares++;
            $display("FAIL arst_now got out=%b ps=%b exp out=0 ps=0", output_value, period_start);
        end
        enable = 1'b0;
        #10;
        reset_n = 1'b1;
        step();
        step();
        vectors++;
        if (output_value !== 1'b0 || period_start !== 1'b0) begin
            miscompares++;
            $display("FAIL arst_idle got out=%b ps=%b exp out=0 ps=0", output_value, period_start);
        end
        enable = 1'b1;
        step();
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (output_value !== 1'b0 || period_start !== 1'b1) begin
                miscompares++;
                $display("FAIL arst_default k=%0d got out=%b ps=%b exp out=0 ps=1", k, output_value, period_start);
            end
            step();
        end
    endtask

    initial begin
        clk__enable = 1'b1;
        reset_n     = 1'b0;
        enable      = 1'b0;
        clk_enable  = 1'b1;
        cfg_valid   = 1'b0;
        period      = 16'd0;
        level       = 16'd0;
        #12;
        reset_n = 1'b1;
        #2;
        test_reset();
        test_basic();
        test_cfg_at_wrap();
        test_period_zero();
        test_slow_tick();
        test_disable_mid();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
